// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem request/done handshake and
// presents {PC+2, instruction} (or a NOP) to the IF/D register every cycle.
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_INSTR   = 16'h0800,
    parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] mem_addr,
    output logic        mem_req,
    input  logic [15:0] mem_data,
    input  logic        mem_done,
    output logic [15:0] PC_add_2_out,
    output logic [15:0] instr_out,
    output logic        instr_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        ISSUE    = 2'd0,
        BUFFERED = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] buf_instr_q, buf_instr_d;
    logic [15:0] buf_pc2_q, buf_pc2_d;
    logic [15:0] drain_pc_q, drain_pc_d;
    logic [15:0] pc_plus2;

    assign pc_plus2 = pc_q + 16'd2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ISSUE;
            pc_q        <= RESET_PC;
            buf_instr_q <= NOP_INSTR;
            buf_pc2_q   <= 16'h0000;
            drain_pc_q  <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc2_q   <= buf_pc2_d;
            drain_pc_q  <= drain_pc_d;
        end
    end

    // In DRAIN the PC keeps the in-flight address; the redirect target waits in drain_pc.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_instr_d  = buf_instr_q;
        buf_pc2_d    = buf_pc2_q;
        drain_pc_d   = drain_pc_q;
        mem_req      = 1'b0;
        mem_addr     = pc_q;
        PC_add_2_out = pc_plus2;
        instr_out    = NOP_INSTR;
        instr_valid  = 1'b0;
        halted       = 1'b0;

        case (state_q)
            ISSUE: begin
                mem_req = 1'b1;
                if (redirect) begin
                    if (mem_done) begin
                        pc_d = redirect_pc;
                    end else begin
                        drain_pc_d = redirect_pc;
                        state_d    = DRAIN;
                    end
                end else if (mem_done) begin
                    instr_out   = mem_data;
                    instr_valid = 1'b1;
                    pc_d        = pc_plus2;
                    if (stall) begin
                        buf_instr_d = mem_data;
                        buf_pc2_d   = pc_plus2;
                        state_d     = BUFFERED;
                    end else if (mem_data[15:11] == HALT_OPCODE) begin
                        state_d = HALTED;
                    end
                end
            end

            BUFFERED: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = ISSUE;
                end else begin
                    instr_out    = buf_instr_q;
                    PC_add_2_out = buf_pc2_q;
                    instr_valid  = 1'b1;
                    if (!stall) begin
                        state_d = (buf_instr_q[15:11] == HALT_OPCODE) ? HALTED : ISSUE;
                    end
                end
            end

            // A redirect landing together with mem_done needs no further draining.
            DRAIN: begin
                mem_req = 1'b1;
                if (redirect) begin
                    if (mem_done) begin
                        pc_d    = redirect_pc;
                        state_d = ISSUE;
                    end else begin
                        drain_pc_d = redirect_pc;
                    end
                end else if (mem_done) begin
                    pc_d    = drain_pc_q;
                    state_d = ISSUE;
                end
            end

            HALTED: begin
                halted = 1'b1;
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = ISSUE;
                end
            end

            default: state_d = ISSUE;
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with fixed expectations
// plus randomized traffic compared against a behavioural fetch model.
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic [15:0] mem_data = 16'h0000;
    logic        mem_done = 1'b0;
    logic [15:0] PC_add_2_out;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        halted;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: a PC, an optional held instruction, a halt flag and an
    // optional pending redirect target waiting for an old request to finish.
    logic [15:0] m_pc;
    logic        m_held;
    logic [15:0] m_held_instr;
    logic [15:0] m_held_pc2;
    logic        m_halted;
    logic        m_drain;
    logic [15:0] m_target;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_addr    (mem_addr),
        .mem_req     (mem_req),
        .mem_data    (mem_data),
        .mem_done    (mem_done),
        .PC_add_2_out(PC_add_2_out),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    function automatic logic isHalt(input logic [15:0] w);
        return (w[15:11] == 5'b00000);
    endfunction

    function automatic logic modelReq();
        return !m_held && !m_halted;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic rd,
                                 input logic [15:0] rpc, input logic d,
                                 input logic [15:0] dat);
        @(negedge clk);
        rst         = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        mem_done    = d;
        mem_data    = dat;
        #1;
    endtask

    // Compares the DUT against the model for this cycle, then advances the model at the edge.
    task automatic checkOutput();
        logic        e_req;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [15:0] e_pc2;
        e_req   = modelReq();
        e_valid = 1'b0;
        e_instr = NOP;
        e_pc2   = 16'h0000;
        if (!redirect) begin
            if (m_held) begin
                e_valid = 1'b1;
                e_instr = m_held_instr;
                e_pc2   = m_held_pc2;
            end else if (!m_halted && !m_drain && mem_done) begin
                e_valid = 1'b1;
                e_instr = mem_data;
                e_pc2   = m_pc + 16'd2;
            end
        end
        if (!rst) begin
            chk("m_req", {15'd0, mem_req}, {15'd0, e_req});
            if (e_req) chk("m_addr", mem_addr, m_pc);
            chk("m_valid", {15'd0, instr_valid}, {15'd0, e_valid});
            chk("m_instr", instr_out, e_instr);
            if (e_valid) chk("m_pc2", PC_add_2_out, e_pc2);
            chk("m_halted", {15'd0, halted}, {15'd0, m_halted});
        end
        @(posedge clk);
        if (rst) begin
            m_pc = 16'h0000; m_held = 1'b0; m_halted = 1'b0; m_drain = 1'b0; m_target = 16'h0000;
        end else if (redirect) begin
            if (!m_held && !m_halted && !mem_done) begin
                m_drain  = 1'b1;
                m_target = redirect_pc;
            end else begin
                m_pc = redirect_pc; m_held = 1'b0; m_halted = 1'b0; m_drain = 1'b0;
            end
        end else if (m_held) begin
            if (!stall) begin
                m_held   = 1'b0;
                m_halted = isHalt(m_held_instr);
            end
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (m_drain) begin
            if (mem_done) begin
                m_drain = 1'b0;
                m_pc    = m_target;
            end
        end else if (mem_done) begin
            m_pc = m_pc + 16'd2;
            if (stall) begin
                m_held       = 1'b1;
                m_held_instr = mem_data;
                m_held_pc2   = m_pc;
            end else if (isHalt(mem_data)) begin
                m_halted = 1'b1;
            end
        end
    endtask

    initial begin
        m_pc = 16'h0000; m_held = 1'b0; m_halted = 1'b0; m_drain = 1'b0;
        m_target = 16'h0000; m_held_instr = NOP; m_held_pc2 = 16'h0000;

        // Reset, then 0-wait memory streaming three instructions.
        applyStimulus(1, 0, 0, 16'h0000, 0, 16'h0000); checkOutput();
        applyStimulus(1, 0, 0, 16'h0000, 0, 16'h0000); checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 1, 16'h4000);
        chk("zw_addr0", mem_addr, 16'h0000); chk("zw_pc2_0", PC_add_2_out, 16'h0002);
        chk("zw_valid0", {15'd0, instr_valid}, 16'h0001); checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 1, 16'h4100);
        chk("zw_addr1", mem_addr, 16'h0002); chk("zw_pc2_1", PC_add_2_out, 16'h0004);
        chk("zw_instr1", instr_out, 16'h4100); checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 1, 16'h4200);
        chk("zw_addr2", mem_addr, 16'h0004); chk("zw_pc2_2", PC_add_2_out, 16'h0006);
        checkOutput();

        // Reset state, then a 3-cycle latency fetch.
        applyStimulus(1, 0, 0, 16'h0000, 0, 16'h0000); checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("rst_valid", {15'd0, instr_valid}, 16'h0000); chk("rst_instr", instr_out, NOP);
        chk("rst_halted", {15'd0, halted}, 16'h0000); chk("rst_req", {15'd0, mem_req}, 16'h0001);
        chk("rst_addr", mem_addr, 16'h0000); checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("lat_addr", mem_addr, 16'h0000); chk("lat_instr", instr_out, NOP); checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 1, 16'h4300);
        chk("lat_pc2", PC_add_2_out, 16'h0002); chk("lat_instr2", instr_out, 16'h4300);
        checkOutput();

        // Stall on delivery: instruction C123 at 0x0010 held for four cycles.
        applyStimulus(0, 0, 1, 16'h0010, 1, 16'h1111);
        chk("rd_nop", instr_out, NOP); checkOutput();
        applyStimulus(0, 1, 0, 16'h0000, 1, 16'hC123);
        chk("st_instr0", instr_out, 16'hC123); chk("st_pc2_0", PC_add_2_out, 16'h0012); checkOutput();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 16'h0000, 0, 16'h0000);
            chk("st_req", {15'd0, mem_req}, 16'h0000); chk("st_instr", instr_out, 16'hC123);
            chk("st_pc2", PC_add_2_out, 16'h0012); checkOutput();
        end
        applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("st_consume", instr_out, 16'hC123); checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("st_next_addr", mem_addr, 16'h0012); checkOutput();

        // Redirect while a 3-cycle request at 0x0008 is in flight.
        applyStimulus(0, 0, 1, 16'h0008, 1, 16'h2222); checkOutput();
        applyStimulus(0, 0, 1, 16'h0100, 0, 16'h0000);
        chk("dr_addr0", mem_addr, 16'h0008); checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("dr_addr1", mem_addr, 16'h0008); chk("dr_req1", {15'd0, mem_req}, 16'h0001); checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 1, 16'h1234);
        chk("dr_drop", instr_out, NOP); chk("dr_drop_v", {15'd0, instr_valid}, 16'h0000); checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 1, 16'h4400);
        chk("dr_new_addr", mem_addr, 16'h0100); chk("dr_new_pc2", PC_add_2_out, 16'h0102); checkOutput();

        // HALT at 0x0020, then release by redirect to 0x0040.
        applyStimulus(0, 0, 1, 16'h0020, 1, 16'h3333); checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 1, 16'h0000);
        chk("h_instr", instr_out, 16'h0000); chk("h_valid", {15'd0, instr_valid}, 16'h0001); checkOutput();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000);
            chk("h_halted", {15'd0, halted}, 16'h0001); chk("h_req", {15'd0, mem_req}, 16'h0000);
            chk("h_nop", instr_out, NOP); checkOutput();
        end
        applyStimulus(0, 0, 1, 16'h0040, 0, 16'h0000); checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("h_release", {15'd0, halted}, 16'h0000); chk("h_addr", mem_addr, 16'h0040); checkOutput();

        // Redirect together with stall while BUFFERED.
        applyStimulus(0, 1, 0, 16'h0000, 1, 16'h5555); checkOutput();
        applyStimulus(0, 1, 1, 16'h0080, 0, 16'h0000);
        chk("bs_nop", instr_out, NOP); chk("bs_valid", {15'd0, instr_valid}, 16'h0000); checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("bs_addr", mem_addr, 16'h0080); chk("bs_req", {15'd0, mem_req}, 16'h0001); checkOutput();

        // PC wrap at the top of the address space.
        applyStimulus(0, 0, 1, 16'hFFFE, 1, 16'h0000); checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 1, 16'h4500);
        chk("wrap_pc2", PC_add_2_out, 16'h0000); checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("wrap_addr", mem_addr, 16'h0000); checkOutput();

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic        r_rst, r_stall, r_rd, r_done;
            logic [15:0] r_rpc, r_data;
            r_rst   = ($urandom_range(0, 99) == 0);
            r_stall = ($urandom_range(0, 9) < 3);
            r_rd    = ($urandom_range(0, 99) < 8);
            r_rpc   = 16'($urandom_range(0, 65535)) & 16'hFFFE;
            r_done  = modelReq() && ($urandom_range(0, 1) == 1);
            r_data  = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 7) == 0) r_data = r_data & 16'h07FF;
            applyStimulus(r_rst, r_stall, r_rd, r_rpc, r_done, r_data);
            checkOutput();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
